// File: rtl/x_top_uart_tx_fifo.sv
// x_top_uart_tx_fifo: UART transmitter fed by a small power-of-two word FIFO.
// Parity stage is compiled in only when X_TOP_UART_TX_PARITY_EN is defined.
module x_top_uart_tx_fifo #(
  parameter int unsigned p_clk_hz     = 12000000,
  parameter int unsigned p_baud       = 115200,
  parameter int unsigned p_data_bits  = 8,
  parameter int unsigned p_stop_bits  = 1,
  parameter int unsigned p_parity     = 0,
  parameter int unsigned p_fifo_depth = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [p_data_bits-1:0]          i_data,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic                            o_tx,
  output logic                            o_busy,
  output logic [$clog2(p_fifo_depth):0]   o_level,
  output logic                            o_done
);

  localparam int unsigned BIT_CYC = p_clk_hz / p_baud;
  localparam int unsigned CNT_W   = $clog2(BIT_CYC);
  localparam int unsigned AW      = $clog2(p_fifo_depth);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned IDX_W   = 4;

  // Elaboration-time parameter sanity checks
  if (BIT_CYC < 2) begin : g_chk_baud
    $error("x_top_uart_tx_fifo: p_clk_hz/p_baud must be at least 2");
  end
  if (p_data_bits < 5 || p_data_bits > 9) begin : g_chk_data
    $error("x_top_uart_tx_fifo: p_data_bits must be 5..9");
  end
  if (p_stop_bits < 1 || p_stop_bits > 2) begin : g_chk_stop
    $error("x_top_uart_tx_fifo: p_stop_bits must be 1 or 2");
  end
  if (p_parity > 2) begin : g_chk_parity
    $error("x_top_uart_tx_fifo: p_parity must be 0, 1 or 2");
  end
  if (p_fifo_depth < 2 || (p_fifo_depth & (p_fifo_depth - 1)) != 0) begin : g_chk_depth
    $error("x_top_uart_tx_fifo: p_fifo_depth must be a power of two >= 2");
  end

`ifdef X_TOP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam bit PAR_ON  = (p_parity != 0);
  localparam bit PAR_ODD = (p_parity == 2);
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t                 state, state_nxt;
  logic [p_data_bits-1:0] mem [p_fifo_depth];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [p_data_bits-1:0] shreg;
  logic                   push_c, pop_c, tx_c, done_c;
  logic                   bit_end_c, last_data_c, last_stop_c, has_word_c;

  assign o_ready     = (level != LW'(p_fifo_depth));
  assign o_level     = level;
  assign push_c      = i_valid & o_ready;
  assign has_word_c  = (level != '0);
  assign bit_end_c   = (cnt == CNT_W'(BIT_CYC - 1));
  assign last_data_c = (idx == IDX_W'(p_data_bits - 1));
  assign last_stop_c = (idx == IDX_W'(p_stop_bits - 1));

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (push_c) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

`ifdef X_TOP_UART_TX_PARITY_EN
  logic par_bit;

  // Parity is latched from the popped word so later FIFO traffic cannot disturb it
  always_ff @(posedge i_clk) begin
    if (i_rst)      par_bit <= 1'b0;
    else if (pop_c) par_bit <= (^mem[rd_ptr]) ^ PAR_ODD;
  end
`endif

  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    tx_c      = 1'b1;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (has_word_c) begin
          pop_c     = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_c = 1'b0;
        if (bit_end_c) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_c = shreg[0];
        if (bit_end_c && last_data_c) begin
`ifdef X_TOP_UART_TX_PARITY_EN
          state_nxt = PAR_ON ? ST_PARITY : ST_STOP;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef X_TOP_UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_c = par_bit;
        if (bit_end_c) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end_c && last_stop_c) begin
          done_c = 1'b1;
          if (has_word_c) begin
            pop_c     = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit timing, shift register and registered line outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_tx   <= tx_c;
      o_busy <= (state != ST_IDLE);
      o_done <= done_c;
      if (state == ST_IDLE || bit_end_c) cnt <= '0;
      else                               cnt <= cnt + CNT_W'(1);
      if (bit_end_c) idx <= (state_nxt != state) ? '0 : idx + IDX_W'(1);
      if (pop_c)                              shreg <= mem[rd_ptr];
      else if (bit_end_c && state == ST_DATA) shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_x_top_uart_tx_fifo.sv
// Bench for x_top_uart_tx_fifo: two instances (8-bit/1 stop, 5-bit/2 stop) checked
// against a frame-waveform model derived from the serial framing rules.
module tb_x_top_uart_tx_fifo;

  localparam int D    = 12;
  localparam int MAXL = 256;
`ifdef X_TOP_UART_TX_PARITY_EN
  localparam int PAR_A = 1;
  localparam int PAR_B = 2;
`else
  localparam int PAR_A = 0;
  localparam int PAR_B = 0;
`endif
  localparam int NB_A = 8, NS_A = 1, NB_B = 5, NS_B = 2;
  localparam int L_A  = D * (1 + NB_A + (PAR_A != 0 ? 1 : 0) + NS_A);
  localparam int L_B  = D * (1 + NB_B + (PAR_B != 0 ? 1 : 0) + NS_B);

  typedef struct {
    int              inst;
    int              gap;
    logic [MAXL-1:0] tx;
    logic [MAXL-1:0] dn;
  } frame_t;

  logic       clk, rst;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic       valid_a, valid_b;
  logic       ready_w [2];
  logic       tx_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic [2:0] level_w [2];

  int checks = 0;
  int errors = 0;
  frame_t rxq[$];

  x_top_uart_tx_fifo #(.p_clk_hz(12000000), .p_baud(1000000), .p_data_bits(8),
                       .p_stop_bits(1), .p_parity(1), .p_fifo_depth(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a), .o_ready(ready_w[0]),
    .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_level(level_w[0]), .o_done(done_w[0]));

  x_top_uart_tx_fifo #(.p_clk_hz(12000000), .p_baud(1000000), .p_data_bits(5),
                       .p_stop_bits(2), .p_parity(2), .p_fifo_depth(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b), .o_ready(ready_w[1]),
    .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_level(level_w[1]), .o_done(done_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lenof(input int i);
    return (i == 0) ? L_A : L_B;
  endfunction

  // Expected line waveform: START, data LSB first, optional parity, stop bits; D cycles each
  function automatic logic [MAXL-1:0] exp_wave(input int i, input int unsigned w);
    logic [MAXL-1:0] v;
    int nb, ns, par, ones, k;
    logic b;
    nb  = (i == 0) ? NB_A : NB_B;
    ns  = (i == 0) ? NS_A : NS_B;
    par = (i == 0) ? PAR_A : PAR_B;
    ones = 0;
    for (int j = 0; j < nb; j++) ones += int'((w >> j) & 1);
    v = '1;
    for (int c = 0; c < D * (1 + nb + (par != 0 ? 1 : 0) + ns); c++) begin
      k = c / D;
      if (k == 0)                       b = 1'b0;
      else if (k <= nb)                 b = 1'((w >> (k - 1)) & 1);
      else if (par != 0 && k == nb + 1) b = 1'((par == 1) ? (ones % 2) : (1 - ones % 2));
      else                              b = 1'b1;
      v[c] = b;
    end
    return v;
  endfunction

  function automatic logic [MAXL-1:0] exp_done(input int i);
    logic [MAXL-1:0] v;
    v = '0;
    v[lenof(i) - 1] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [MAXL-1:0] obs, input logic [MAXL-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Line monitor: records each frame cycle by cycle, plus idle cycles before it
  initial begin
    int cyc [2];
    int idle [2];
    frame_t cur [2];
    for (int i = 0; i < 2; i++) begin cyc[i] = -1; idle[i] = 1000; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cyc[i] < 0 && tx_w[i] === 1'b0) begin
          cyc[i] = 0;
          cur[i].inst = i;
          cur[i].gap  = idle[i];
          cur[i].tx   = '1;
          cur[i].dn   = '0;
        end
        if (cyc[i] >= 0) begin
          if (busy_w[i] !== 1'b1) begin
            cyc[i]  = -1;
            idle[i] = 1000;
          end else begin
            cur[i].tx[cyc[i]] = tx_w[i];
            cur[i].dn[cyc[i]] = done_w[i];
            cyc[i]++;
            if (cyc[i] == lenof(i)) begin
              rxq.push_back(cur[i]);
              cyc[i]  = -1;
              idle[i] = 0;
            end
          end
        end else begin
          idle[i]++;
        end
      end
    end
  end

  task automatic check_frame(input int i, input int unsigned w, input bit chk_gap, input string tag);
    frame_t f;
    int n;
    n = 0;
    while (rxq.size() == 0 && n < 3000) begin @(posedge clk); n++; end
    chk({tag, "_arrive"}, MAXL'(rxq.size() != 0), 1);
    if (rxq.size() != 0) begin
      f = rxq.pop_front();
      chk({tag, "_inst"}, MAXL'(f.inst), MAXL'(i));
      chk({tag, "_wave"}, f.tx, exp_wave(i, w));
      chk({tag, "_done"}, f.dn, exp_done(i));
      if (chk_gap) chk({tag, "_gap"}, MAXL'(f.gap), 0);
    end
  endtask

  task automatic push_a(input int unsigned w);
    data_a  = 8'(w);
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic push_b(input int unsigned w);
    data_b  = 5'(w);
    valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  initial begin
    int unsigned w [4];
    int accepted, k;
    bit acc, saw_full;

    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx", MAXL'(tx_w[i]), 1);
      chk("rst_busy", MAXL'(busy_w[i]), 0);
      chk("rst_done", MAXL'(done_w[i]), 0);
      chk("rst_level", MAXL'(level_w[i]), 0);
      chk("rst_ready", MAXL'(ready_w[i]), 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency from accepting edge E to line low, then the 0xA5 frame
    push_a(32'hA5);
    chk("lat_e0_tx", MAXL'(tx_w[0]), 1);
    chk("lat_e0_lvl", MAXL'(level_w[0]), 1);
    @(negedge clk);
    chk("lat_e1_tx", MAXL'(tx_w[0]), 1);
    chk("lat_e1_lvl", MAXL'(level_w[0]), 0);
    @(negedge clk);
    chk("lat_e2_tx", MAXL'(tx_w[0]), 0);
    chk("lat_e2_busy", MAXL'(busy_w[0]), 1);
    check_frame(0, 32'hA5, 1'b0, "a5");

    push_b(32'h13);
    check_frame(1, 32'h13, 1'b0, "b13");

    for (int n = 0; n < 4; n++) begin
      w[0] = $urandom_range(0, 255);
      push_a(w[0]);
      check_frame(0, w[0], 1'b0, "rand_a");
    end
    for (int n = 0; n < 3; n++) begin
      w[0] = $urandom_range(0, 31);
      push_b(w[0]);
      check_frame(1, w[0], 1'b0, "rand_b");
    end

    // Hold i_valid with 1..6 while the line is busy: five accepted, FIFO full
    @(negedge clk);
    accepted = 0; saw_full = 1'b0; k = 1;
    data_a = 8'(k); valid_a = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc = ready_w[0];
      @(negedge clk);
      if (acc) begin
        accepted++;
        if (k < 6) begin k++; data_a = 8'(k); end
      end
      if (level_w[0] == 3'd4 && ready_w[0] == 1'b0) saw_full = 1'b1;
    end
    valid_a = 1'b0;
    chk("full_accepted", MAXL'(accepted), 5);
    chk("full_seen", MAXL'(saw_full), 1);
    chk("full_level", MAXL'(level_w[0]), 4);
    chk("full_ready", MAXL'(ready_w[0]), 0);
    for (int j = 1; j <= 5; j++) check_frame(0, j, j != 1, "b2b");

    // Push on the same edge as the end-of-frame pop with level 2
    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++) w[j] = $urandom_range(0, 255);
    data_a = 8'(w[0]); valid_a = 1'b1;
    @(negedge clk); data_a = 8'(w[1]);
    @(negedge clk); data_a = 8'(w[2]);
    @(negedge clk); valid_a = 1'b0;
    chk("pp_level_pre", MAXL'(level_w[0]), 2);
    repeat (L_A - 2) @(negedge clk);
    chk("pp_level_edge", MAXL'(level_w[0]), 2);
    data_a = 8'(w[3]); valid_a = 1'b1;
    @(negedge clk); valid_a = 1'b0;
    chk("pp_level_post", MAXL'(level_w[0]), 2);
    for (int j = 0; j < 4; j++) check_frame(0, w[j], j != 0, "pp");

    // Reset during data bit 3 with two words queued
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) w[j] = $urandom_range(0, 255);
    data_a = 8'(w[0]); valid_a = 1'b1;
    @(negedge clk); data_a = 8'(w[1]);
    @(negedge clk); data_a = 8'(w[2]);
    @(negedge clk); valid_a = 1'b0;
    chk("ab_level", MAXL'(level_w[0]), 2);
    repeat (52) @(negedge clk);
    chk("ab_bit3", MAXL'(tx_w[0]), MAXL'((w[0] >> 3) & 1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_tx", MAXL'(tx_w[0]), 1);
    chk("ab_level0", MAXL'(level_w[0]), 0);
    chk("ab_busy", MAXL'(busy_w[0]), 0);
    chk("ab_ready", MAXL'(ready_w[0]), 1);
    repeat (300) @(negedge clk);
    chk("ab_no_frames", MAXL'(rxq.size()), 0);
    chk("ab_idle_tx", MAXL'(tx_w[0]), 1);
    chk("ab_idle_busy", MAXL'(busy_w[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
